pcm1802_i2s_receiver: RTL and testbench



---
 rtl/pcm1802_i2s_receiver.sv | 191 +++++++++++++++++++
 tb/tb_pcm1802_i2s_receiver.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pcm1802_i2s_receiver.sv
// PCM1802 I2S receiver: oversamples the asynchronous BCK/LRCK/DOUT pins in the
// system clock domain, deserialises 24-bit left/right words and presents a
// complete stereo pair only once the stream has shown LOCK_FRAMES good frames.
//
// Output handshake: pcm_ready is a one-cycle strobe. pcm_left_out and
// pcm_right_out change only in the cycle pcm_ready is high, always together,
// and hold their values at every other time. There is no back-pressure: the
// consumer must take the pair in the strobe cycle.
module pcm1802_i2s_receiver #(
    parameter int DATA_BITS      = 24,
    parameter int SYNC_STAGES    = 2,
    parameter int LOCK_FRAMES    = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clock,
    input  logic                 nReset,
    input  logic                 pcm_bck,
    input  logic                 pcm_lrck,
    input  logic                 pcm_dout,
    output logic [DATA_BITS-1:0] pcm_left_out,
    output logic [DATA_BITS-1:0] pcm_right_out,
    output logic                 pcm_ready,
    output logic                 locked,
    output logic                 frame_error
);

    localparam int BIT_W  = $clog2(DATA_BITS + 1);
    localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_FRAMES);
    localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WAIT  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] bck_sync;
    logic [SYNC_STAGES-1:0] lrck_sync;
    logic [SYNC_STAGES-1:0] dout_sync;
    logic                   bck_d;
    logic                   lrck_prev;

    state_t                 state;
    logic                   channel;      // 0 = left, 1 = right
    logic [BIT_W-1:0]       bit_cnt;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [DATA_BITS-1:0]   left_hold;
    logic                   left_valid;
    logic [GOOD_W-1:0]      good_cnt;
    logic [TMO_W-1:0]       timeout_cnt;

    logic                   bck_s;
    logic                   lrck_s;
    logic                   dout_s;
    logic                   bck_rise;
    logic                   chan_start;
    logic                   timeout_hit;
    logic [DATA_BITS-1:0]   shift_next;
    logic [GOOD_W-1:0]      good_next;

    assign bck_s  = bck_sync[SYNC_STAGES-1];
    assign lrck_s = lrck_sync[SYNC_STAGES-1];
    assign dout_s = dout_sync[SYNC_STAGES-1];

    // Capture strobes derived from the synchronised pins. A channel start is
    // the I2S one-bit delay slot, so it never carries captured data.
    assign bck_rise    = bck_s & ~bck_d;
    assign chan_start  = bck_rise & (lrck_s != lrck_prev);
    assign timeout_hit = ~chan_start & (timeout_cnt == TMO_LAST);
    assign shift_next  = {shift_reg[DATA_BITS-2:0], dout_s};
    assign good_next   = (good_cnt == GOOD_MAX) ? good_cnt : good_cnt + 1'b1;

    // Multi-flop synchronisers on the asynchronous pins plus the bck history bit.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            bck_sync  <= '0;
            lrck_sync <= '0;
            dout_sync <= '0;
            bck_d     <= 1'b0;
        end else begin
            bck_sync  <= {bck_sync[SYNC_STAGES-2:0], pcm_bck};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], pcm_lrck};
            dout_sync <= {dout_sync[SYNC_STAGES-2:0], pcm_dout};
            bck_d     <= bck_s;
        end
    end

    // Cycles since the last LRCK edge; a channel start always wins over expiry.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            timeout_cnt <= '0;
        end else if (chan_start) begin
            timeout_cnt <= '0;
        end else if (timeout_cnt != TMO_MAX) begin
            timeout_cnt <= timeout_cnt + 1'b1;
        end
    end

    // Framing FSM with lock supervision and registered output strobes.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state         <= IDLE;
            channel       <= 1'b0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            left_hold     <= '0;
            left_valid    <= 1'b0;
            good_cnt      <= '0;
            lrck_prev     <= 1'b0;
            locked        <= 1'b0;
            pcm_ready     <= 1'b0;
            frame_error   <= 1'b0;
            pcm_left_out  <= '0;
            pcm_right_out <= '0;
        end else begin
            pcm_ready   <= 1'b0;
            frame_error <= 1'b0;
            if (bck_rise) begin
                lrck_prev <= lrck_s;
            end

            case (state)
                IDLE: begin
                    // Only a left start qualifies; a right start here is ignored.
                    if (chan_start && !lrck_s) begin
                        state   <= SHIFT;
                        channel <= 1'b0;
                        bit_cnt <= '0;
                    end
                end

                SHIFT: begin
                    if (chan_start) begin
                        // Word cut short: drop everything and requalify on a left start.
                        frame_error <= 1'b1;
                        good_cnt    <= '0;
                        locked      <= 1'b0;
                        left_valid  <= 1'b0;
                        left_hold   <= '0;
                        state       <= IDLE;
                    end else if (bck_rise) begin
                        shift_reg <= shift_next;
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            state <= WAIT;
                            if (!channel) begin
                                left_hold  <= shift_next;
                                left_valid <= 1'b1;
                            end else if (left_valid) begin
                                // Frame complete: both words of one frame are in hand.
                                left_valid <= 1'b0;
                                good_cnt   <= good_next;
                                if (good_next == GOOD_MAX) begin
                                    locked        <= 1'b1;
                                    pcm_left_out  <= left_hold;
                                    pcm_right_out <= shift_next;
                                    pcm_ready     <= 1'b1;
                                end
                            end
                        end
                    end
                end

                WAIT: begin
                    // Trailing slot bits are ignored until the next channel start.
                    if (chan_start) begin
                        state   <= SHIFT;
                        channel <= lrck_s;
                        bit_cnt <= '0;
                    end
                end

                default: state <= IDLE;
            endcase

            // A silent stream drops lock without flagging a framing fault.
            if (timeout_hit) begin
                locked     <= 1'b0;
                good_cnt   <= '0;
                left_valid <= 1'b0;
                state      <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_pcm1802_i2s_receiver.sv
// Directed bench for pcm1802_i2s_receiver: drives I2S frames at BCK = clock/13,
// predicts each ready pulse (cycle and data) into a queue, and checks pulses
// as they appear along with lock, timeout, short-word and reset behaviour.
module tb_pcm1802_i2s_receiver;

  localparam int DATA_BITS   = 24;
  localparam int SYNC_STAGES = 2;
  localparam int LOCK_FRAMES = 4;
  localparam int TIMEOUT     = 4096;
  // Pin change -> synchroniser stages -> edge register -> registered strobe.
  localparam int READY_LAT   = SYNC_STAGES + 1;

  logic                 clock = 1'b0;
  logic                 nReset = 1'b0;
  logic                 pcm_bck = 1'b0;
  logic                 pcm_lrck = 1'b1;
  logic                 pcm_dout = 1'b0;
  logic [DATA_BITS-1:0] pcm_left_out;
  logic [DATA_BITS-1:0] pcm_right_out;
  logic                 pcm_ready;
  logic                 locked;
  logic                 frame_error;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int err_pulses = 0;
  int ready_pulses = 0;
  int good = 0;
  int last_lr_cyc = 0;
  int e0;
  int r0;

  // {expected ready cycle[79:48], left[47:24], right[23:0]}
  logic [79:0] exp_q[$];

  pcm1802_i2s_receiver #(
    .DATA_BITS(DATA_BITS),
    .SYNC_STAGES(SYNC_STAGES),
    .LOCK_FRAMES(LOCK_FRAMES),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clock(clock),
    .nReset(nReset),
    .pcm_bck(pcm_bck),
    .pcm_lrck(pcm_lrck),
    .pcm_dout(pcm_dout),
    .pcm_left_out(pcm_left_out),
    .pcm_right_out(pcm_right_out),
    .pcm_ready(pcm_ready),
    .locked(locked),
    .frame_error(frame_error)
  );

  // clock and cycle counter
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every ready pulse must match the head of the expected queue
  always @(negedge clock) begin
    logic [79:0] e;
    if (frame_error) err_pulses++;
    if (pcm_ready) begin
      ready_pulses++;
      check("ready_while_locked", 32'(locked), 1);
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL ready_unexpected observed=1 expected=0 cycle=%0d", cyc);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ready_cycle", 32'(cyc), e[79:48]);
        check("ready_left", 32'(pcm_left_out), 32'(e[47:24]));
        check("ready_right", 32'(pcm_right_out), 32'(e[23:0]));
      end
    end
  end

  // One channel slot: a delay rise, nbits data bits MSB first, zero fill up to
  // 'rises'. With push set, the expected pair is queued at the last data rise.
  task automatic send_slot(input logic lr, input logic [DATA_BITS-1:0] word,
                           input int nbits, input int rises,
                           input logic push, input logic [DATA_BITS-1:0] left);
    for (int i = 0; i < rises; i++) begin
      logic b;
      b = 1'b0;
      if (i >= 1 && i <= nbits) b = word[DATA_BITS-i];
      pcm_bck = 1'b0;
      pcm_lrck = lr;
      pcm_dout = b;
      repeat (6) @(negedge clock);
      pcm_bck = 1'b1;
      if (i == 0) last_lr_cyc = cyc;
      if (push && i == nbits) exp_q.push_back({32'(cyc + READY_LAT), left, word});
      repeat (7) @(negedge clock);
    end
  endtask

  // A full good frame; the bench's lock model decides whether a pair is due.
  task automatic send_frame(input logic [DATA_BITS-1:0] l, input logic [DATA_BITS-1:0] r,
                            input int slot);
    int g;
    g = (good < LOCK_FRAMES) ? good + 1 : LOCK_FRAMES;
    send_slot(1'b0, l, DATA_BITS, slot, 1'b0, '0);
    send_slot(1'b1, r, DATA_BITS, slot, (g == LOCK_FRAMES), l);
    good = g;
  endtask

  // Four frames from an unlocked state: lock must appear exactly on the fourth.
  task automatic relock(input logic [DATA_BITS-1:0] l, input logic [DATA_BITS-1:0] r,
                        input string tag);
    for (int f = 1; f <= LOCK_FRAMES; f++) begin
      send_frame(l, r, 32);
      if (f == LOCK_FRAMES - 1) check({tag, "_unlocked_f3"}, 32'(locked), 0);
    end
    check({tag, "_locked_f4"}, 32'(locked), 1);
    check({tag, "_left"}, 32'(pcm_left_out), 32'(l));
    check({tag, "_right"}, 32'(pcm_right_out), 32'(r));
  endtask

  initial begin
    // reset
    repeat (5) @(negedge clock);
    check("rst_left", 32'(pcm_left_out), 0);
    check("rst_right", 32'(pcm_right_out), 0);
    check("rst_ready", 32'(pcm_ready), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_frame_error", 32'(frame_error), 0);
    nReset = 1'b1;
    repeat (3) @(negedge clock);
    // right-channel tail from IDLE: must be ignored
    send_slot(1'b1, '0, 0, 4, 1'b0, '0);

    // scenario 1: lock and first ready
    r0 = ready_pulses;
    for (int f = 1; f <= 6; f++) begin
      send_frame(24'h123456, 24'hABCDEF, 32);
      if (f == 3) begin
        check("s1_unlocked_f3", 32'(locked), 0);
        check("s1_no_ready_f1_3", 32'(ready_pulses - r0), 0);
      end
      if (f == 4) check("s1_locked_f4", 32'(locked), 1);
    end
    check("s1_ready_count", 32'(ready_pulses - r0), 3);
    check("s1_left", 32'(pcm_left_out), 32'h123456);
    check("s1_right", 32'(pcm_right_out), 32'hABCDEF);

    // scenario 2: full-scale values
    send_frame(24'h800000, 24'h7FFFFF, 32);
    check("s2_left_a", 32'(pcm_left_out), 32'h800000);
    check("s2_right_a", 32'(pcm_right_out), 32'h7FFFFF);
    send_frame(24'h000001, 24'hFFFFFF, 32);
    check("s2_left_b", 32'(pcm_left_out), 32'h000001);
    check("s2_right_b", 32'(pcm_right_out), 32'hFFFFFF);

    // scenario 3: short left word (20 bits) while locked
    e0 = err_pulses;
    r0 = ready_pulses;
    send_slot(1'b0, 24'hC3C3C3, 20, 21, 1'b0, '0);
    send_slot(1'b1, 24'h3C3C3C, DATA_BITS, 32, 1'b0, '0);
    good = 0;
    check("s3_error_pulses", 32'(err_pulses - e0), 1);
    check("s3_unlocked", 32'(locked), 0);
    check("s3_no_ready", 32'(ready_pulses - r0), 0);
    check("s3_hold_left", 32'(pcm_left_out), 32'h000001);
    check("s3_hold_right", 32'(pcm_right_out), 32'hFFFFFF);
    relock(24'h55AA33, 24'h0CC0FF, "s3_relock");

    // scenario 4: stream stops; lock drops TIMEOUT cycles after the last LRCK edge
    e0 = err_pulses;
    while (cyc < last_lr_cyc + READY_LAT + TIMEOUT - 1) @(negedge clock);
    check("s4_locked_before_timeout", 32'(locked), 1);
    @(negedge clock);
    check("s4_unlocked_at_timeout", 32'(locked), 0);
    while (cyc < last_lr_cyc + 5000) @(negedge clock);
    check("s4_no_frame_error", 32'(err_pulses - e0), 0);
    good = 0;
    relock(24'hA5A5A5, 24'h5A5A5A, "s4_relock");

    // scenario 5: reset in the middle of a right word
    send_slot(1'b0, 24'h111111, DATA_BITS, 32, 1'b0, '0);
    send_slot(1'b1, 24'h222222, 10, 11, 1'b0, '0);
    nReset = 1'b0;
    #1;
    check("s5_rst_left", 32'(pcm_left_out), 0);
    check("s5_rst_right", 32'(pcm_right_out), 0);
    check("s5_rst_ready", 32'(pcm_ready), 0);
    check("s5_rst_locked", 32'(locked), 0);
    check("s5_rst_frame_error", 32'(frame_error), 0);
    repeat (2) @(negedge clock);
    nReset = 1'b1;
    send_slot(1'b1, '0, 0, 21, 1'b0, '0);
    good = 0;
    relock(24'h7E1234, 24'h81FEDC, "s5_relock");

    // scenario 6: 24-bit slots, data fills the slot up to the next LRCK change
    e0 = err_pulses;
    send_frame(24'h0F0F0F, 24'hF0F0F0, DATA_BITS + 1);
    check("s6_left_a", 32'(pcm_left_out), 32'h0F0F0F);
    check("s6_right_a", 32'(pcm_right_out), 32'hF0F0F0);
    send_frame(24'hF0F0F0, 24'h0F0F0F, DATA_BITS + 1);
    check("s6_left_b", 32'(pcm_left_out), 32'hF0F0F0);
    check("s6_right_b", 32'(pcm_right_out), 32'h0F0F0F);
    check("s6_no_frame_error", 32'(err_pulses - e0), 0);

    // final report
    repeat (20) @(negedge clock);
    check("pending_ready_pairs", 32'(exp_q.size()), 0);
    check("total_frame_errors", 32'(err_pulses), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
